// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one programmable bit-serial pattern detector
// among NCH serial channels; hits are tagged with the source channel and counted.
module seq_detect_sched #(
    parameter int               NCH     = 4,
    parameter int               PAT_W   = 8,
    parameter int               BURST   = 16,
    parameter logic [PAT_W-1:0] PATTERN = 8'b01110001
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         req,
    input  logic [NCH-1:0]         din,
    output logic [NCH-1:0]         gnt,
    output logic                   busy,
    input  logic                   cfg_we,
    input  logic [PAT_W-1:0]       cfg_pattern,
    output logic                   match,
    output logic [$clog2(NCH)-1:0] match_ch,
    output logic [15:0]            match_cnt
);
    localparam int CW = $clog2(NCH);
    localparam int FW = $clog2(PAT_W + 1);
    localparam int BW = $clog2(BURST + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    ptr_q, cur_q, pick;
    logic [CW:0]      scan;
    logic             found, start, done;
    logic [PAT_W-1:0] hist_q, hist_d, pat_q;
    logic [FW-1:0]    fill_q;
    logic [BW-1:0]    bcnt_q;
    logic             consume, hit, last;

    // First requester at or after the rr pointer, wrapping modulo NCH.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        scan  = '0;
        for (int k = 0; k < NCH; k++) begin
            scan = {1'b0, ptr_q} + (CW+1)'(k);
            if (scan >= (CW+1)'(NCH))
                scan = scan - (CW+1)'(NCH);
            if (!found && req[scan[CW-1:0]]) begin
                found = 1'b1;
                pick  = scan[CW-1:0];
            end
        end
    end

    assign consume = (state_q == RUN) && req[cur_q];
    assign hist_d  = {hist_q[PAT_W-2:0], din[cur_q]};
    // fill_q counts bits before this one, so PAT_W-1 means the window is full after the shift.
    assign hit     = consume && (hist_d == pat_q) && (fill_q >= FW'(PAT_W - 1));
    assign last    = (bcnt_q == BW'(BURST - 1));
    assign busy    = (state_q == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cfg_we && found) begin
                    state_d = RUN;
                    start   = 1'b1;
                end
            end
            RUN: begin
                if (!consume || last) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            ptr_q     <= '0;
            cur_q     <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            bcnt_q    <= '0;
            pat_q     <= PATTERN;
            match     <= 1'b0;
            match_ch  <= '0;
            match_cnt <= '0;
        end else begin
            match <= hit;
            if (hit) begin
                match_ch <= cur_q;
                if (match_cnt != 16'hFFFF)
                    match_cnt <= match_cnt + 16'd1;
            end
            if (state_q == IDLE && cfg_we) begin
                pat_q     <= cfg_pattern;
                match_cnt <= '0;
            end
            if (start) begin
                gnt    <= NCH'(1) << pick;
                cur_q  <= pick;
                hist_q <= '0;
                fill_q <= '0;
                bcnt_q <= '0;
            end
            if (consume) begin
                hist_q <= hist_d;
                bcnt_q <= bcnt_q + BW'(1);
                if (fill_q != FW'(PAT_W))
                    fill_q <= fill_q + FW'(1);
            end
            if (done) begin
                gnt   <= '0;
                ptr_q <= (cur_q == CW'(NCH - 1)) ? '0 : cur_q + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_seq_detect_sched.sv
// Bench for seq_detect_sched: directed scenarios plus random traffic, every cycle
// compared against a grant/bit-queue reference model.
module tb_seq_detect_sched;
    localparam int NCH = 4;
    localparam int PAT_W = 8;
    localparam int BURST = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [NCH-1:0]   req = '0, din = '0, gnt;
    logic             busy, cfg_we = 1'b0, match;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [1:0]       match_ch;
    logic [15:0]      match_cnt;

    int checks = 0;
    int passes = 0;

    seq_detect_sched #(.NCH(NCH), .PAT_W(PAT_W), .BURST(BURST), .PATTERN(8'b01110001)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din), .gnt(gnt), .busy(busy),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .match(match),
        .match_ch(match_ch), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a grant is a session owning a queue of the bits it consumed.
    logic             m_busy, m_match;
    int               m_ch, m_ptr, m_mch;
    bit               m_bits[$];
    logic [PAT_W-1:0] m_pat;
    logic [15:0]      m_cnt;

    function automatic logic [NCH-1:0] m_gnt();
        logic [NCH-1:0] g = '0;
        if (m_busy) g[m_ch] = 1'b1;
        return g;
    endfunction

    function automatic logic [PAT_W-1:0] m_tail();
        logic [PAT_W-1:0] v = '0;
        for (int i = m_bits.size() - PAT_W; i < m_bits.size(); i++)
            v = {v[PAT_W-2:0], m_bits[i]};
        return v;
    endfunction

    task automatic m_reset();
        m_busy = 0; m_match = 0; m_ch = 0; m_ptr = 0; m_mch = 0;
        m_bits.delete(); m_pat = 8'b01110001; m_cnt = 0;
    endtask

    task automatic tick();
        logic [NCH-1:0]   r  = req;
        logic [NCH-1:0]   d  = din;
        logic             cw = cfg_we;
        logic [PAT_W-1:0] cp = cfg_pattern;
        @(posedge clk);
        m_match = 0;
        if (!m_busy) begin
            if (cw) begin
                m_pat = cp;
                m_cnt = 0;
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    if (r[(m_ptr + k) % NCH]) begin
                        m_busy = 1; m_ch = (m_ptr + k) % NCH; m_bits.delete();
                        break;
                    end
                end
            end
        end else if (r[m_ch]) begin
            m_bits.push_back(d[m_ch]);
            if (m_bits.size() >= PAT_W && m_tail() == m_pat) begin
                m_match = 1; m_mch = m_ch;
                if (m_cnt != 16'hFFFF) m_cnt++;
            end
            if (m_bits.size() == BURST) begin
                m_busy = 0; m_ptr = (m_ch + 1) % NCH;
            end
        end else begin
            m_busy = 0; m_ptr = (m_ch + 1) % NCH;
        end
        #1;
    endtask

    // Drive channel ch with stream s (MSB first) for len bits, zeros after, random elsewhere.
    task automatic drive(input int ch, input logic [31:0] s, input int len);
        din = NCH'($urandom);
        if (m_busy && m_ch == ch)
            din[ch] = (m_bits.size() < len) ? s[len - 1 - m_bits.size()] : 1'b0;
    endtask

    task automatic do_reset();
        req = '0; din = '0; cfg_we = 0; cfg_pattern = '0;
        rst_n = 0;
        #1;
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        #2 rst_n = 0;
        #1;
        m_reset();
        checks++;
        if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
        checks++;
        if (match !== 1'b0) $display("FAIL reset_match: got %b want 0", match); else passes++;
        checks++;
        if (match_ch !== 2'd0) $display("FAIL reset_match_ch: got %0d want 0", match_ch); else passes++;
        checks++;
        if (match_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", match_cnt); else passes++;
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_single();
        do_reset();
        for (int cyc = 0; cyc < 20; cyc++) begin
            req = 4'b0010;
            drive(1, 32'b01110001, 8);
            tick();
            checks++;
            if ({gnt, busy, match, match_cnt} !== {m_gnt(), m_busy, m_match, m_cnt})
                $display("FAIL single cyc%0d: got gnt=%b busy=%b match=%b cnt=%0d, want gnt=%b busy=%b match=%b cnt=%0d",
                         cyc, gnt, busy, match, match_cnt, m_gnt(), m_busy, m_match, m_cnt);
            else passes++;
            if (m_match) begin
                checks++;
                if (match_ch !== 2'(m_mch)) $display("FAIL single_ch cyc%0d: got %0d want %0d", cyc, match_ch, m_mch); else passes++;
            end
            if (cyc == 0) begin
                checks++;
                if (gnt !== 4'b0010) $display("FAIL single_gnt: got %b want 0010", gnt); else passes++;
            end
            if (cyc == 8) begin
                checks++;
                if ({match, match_ch, match_cnt} !== {1'b1, 2'd1, 16'd1})
                    $display("FAIL single_hit: got match=%b ch=%0d cnt=%0d want 1/1/1", match, match_ch, match_cnt);
                else passes++;
            end
        end
    endtask

    task automatic test_overlap();
        do_reset();
        for (int cyc = 0; cyc < 18; cyc++) begin
            req = 4'b0001;
            drive(0, 32'b01110001110001, 14);
            tick();
            checks++;
            if ({gnt, busy, match, match_cnt} !== {m_gnt(), m_busy, m_match, m_cnt})
                $display("FAIL overlap cyc%0d: got gnt=%b busy=%b match=%b cnt=%0d, want gnt=%b busy=%b match=%b cnt=%0d",
                         cyc, gnt, busy, match, match_cnt, m_gnt(), m_busy, m_match, m_cnt);
            else passes++;
            if (m_match) begin
                checks++;
                if (match_ch !== 2'(m_mch)) $display("FAIL overlap_ch cyc%0d: got %0d want %0d", cyc, match_ch, m_mch); else passes++;
            end
            if (cyc == 14) begin
                checks++;
                if ({match, match_cnt} !== {1'b1, 16'd2})
                    $display("FAIL overlap_hit2: got match=%b cnt=%0d want 1/2", match, match_cnt);
                else passes++;
            end
        end
    endtask

    task automatic test_round_robin();
        logic [NCH-1:0] prev = '0, eg;
        int gi = 0, run = 0, idle = 0;
        do_reset();
        req = 4'b1111;
        din = '0;
        for (int cyc = 0; cyc < 70; cyc++) begin
            tick();
            checks++;
            if ({gnt, busy, match, match_cnt} !== {m_gnt(), m_busy, m_match, m_cnt})
                $display("FAIL rr cyc%0d: got gnt=%b busy=%b match=%b cnt=%0d, want gnt=%b busy=%b match=%b cnt=%0d",
                         cyc, gnt, busy, match, match_cnt, m_gnt(), m_busy, m_match, m_cnt);
            else passes++;
            if (gnt != 0 && prev == 0) begin
                eg = '0;
                eg[gi % NCH] = 1'b1;
                checks++;
                if (gnt !== eg) $display("FAIL rr_order grant%0d: got %b want %b", gi, gnt, eg); else passes++;
                if (gi > 0) begin
                    checks++;
                    if (idle !== 1) $display("FAIL rr_gap grant%0d: got %0d idle cycles want 1", gi, idle); else passes++;
                end
                gi++;
                idle = 0;
            end
            if (gnt == 0 && prev != 0) begin
                checks++;
                if (run !== BURST) $display("FAIL rr_len: got %0d cycles want %0d", run, BURST); else passes++;
                run = 0;
            end
            if (gnt != 0) run++; else idle++;
            prev = gnt;
        end
        checks++;
        if (gi !== 5) $display("FAIL rr_count: got %0d grants want 5", gi); else passes++;
    endtask

    task automatic test_isolation();
        logic [31:0] s;
        do_reset();
        for (int ph = 0; ph < 2; ph++) begin
            s = (ph == 0) ? 32'b0111 : 32'b0001;
            for (int cyc = 0; cyc < 6; cyc++) begin
                req = (cyc < 5) ? 4'b0100 : 4'b0000;
                drive(2, s, 4);
                tick();
                checks++;
                if ({gnt, busy, match, match_cnt} !== {m_gnt(), m_busy, m_match, m_cnt})
                    $display("FAIL iso ph%0d cyc%0d: got gnt=%b busy=%b match=%b cnt=%0d, want gnt=%b busy=%b match=%b cnt=%0d",
                             ph, cyc, gnt, busy, match, match_cnt, m_gnt(), m_busy, m_match, m_cnt);
                else passes++;
            end
        end
        checks++;
        if (match_cnt !== 16'd0) $display("FAIL iso_cnt: got %0d want 0", match_cnt); else passes++;
        req = 4'b1111;
        tick();
        checks++;
        if (gnt !== 4'b1000) $display("FAIL iso_ptr: got %b want 1000", gnt); else passes++;
    endtask

    task automatic test_config();
        do_reset();
        for (int cyc = 0; cyc < 10; cyc++) begin
            req = (cyc < 9) ? 4'b0001 : 4'b0000;
            drive(0, 32'b01110001, 8);
            tick();
            checks++;
            if ({gnt, busy, match, match_cnt} !== {m_gnt(), m_busy, m_match, m_cnt})
                $display("FAIL cfg_pre cyc%0d: got gnt=%b busy=%b match=%b cnt=%0d, want gnt=%b busy=%b match=%b cnt=%0d",
                         cyc, gnt, busy, match, match_cnt, m_gnt(), m_busy, m_match, m_cnt);
            else passes++;
        end
        cfg_we = 1; cfg_pattern = 8'hFF; req = 4'b0001; din = '1;
        tick();
        checks++;
        if ({gnt, match_cnt} !== {4'b0000, 16'd0})
            $display("FAIL cfg_wins: got gnt=%b cnt=%0d want 0000/0", gnt, match_cnt);
        else passes++;
        cfg_we = 0;
        for (int cyc = 0; cyc < 17; cyc++) begin
            tick();
            checks++;
            if ({gnt, busy, match, match_cnt} !== {m_gnt(), m_busy, m_match, m_cnt})
                $display("FAIL cfg_ones cyc%0d: got gnt=%b busy=%b match=%b cnt=%0d, want gnt=%b busy=%b match=%b cnt=%0d",
                         cyc, gnt, busy, match, match_cnt, m_gnt(), m_busy, m_match, m_cnt);
            else passes++;
            if (cyc == 0) begin
                checks++;
                if (gnt !== 4'b0001) $display("FAIL cfg_gnt_next: got %b want 0001", gnt); else passes++;
            end
        end
        checks++;
        if ({match, match_cnt} !== {1'b1, 16'd9})
            $display("FAIL cfg_hits: got match=%b cnt=%0d want 1/9", match, match_cnt);
        else passes++;
    endtask

    task automatic test_run_cfg_reset();
        do_reset();
        cfg_we = 1; cfg_pattern = 8'hFF;
        tick();
        cfg_we = 0;
        for (int cyc = 0; cyc < 11; cyc++) begin
            req = (cyc < 10) ? 4'b0001 : 4'b0000;
            din = '1;
            cfg_we = (cyc == 3);
            cfg_pattern = 8'h00;
            tick();
            checks++;
            if ({gnt, busy, match, match_cnt} !== {m_gnt(), m_busy, m_match, m_cnt})
                $display("FAIL runcfg cyc%0d: got gnt=%b busy=%b match=%b cnt=%0d, want gnt=%b busy=%b match=%b cnt=%0d",
                         cyc, gnt, busy, match, match_cnt, m_gnt(), m_busy, m_match, m_cnt);
            else passes++;
            if (cyc == 9) begin
                checks++;
                if (match_cnt !== 16'd2) $display("FAIL runcfg_ignored: got cnt=%0d want 2", match_cnt); else passes++;
            end
        end
        cfg_we = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            req = 4'b0001; din = '1;
            tick();
        end
        rst_n = 0;
        #1;
        m_reset();
        checks++;
        if ({gnt, busy, match, match_cnt} !== {4'b0000, 1'b0, 1'b0, 16'd0})
            $display("FAIL midrst: got gnt=%b busy=%b match=%b cnt=%0d want all zero", gnt, busy, match, match_cnt);
        else passes++;
        req = '0;
        @(posedge clk);
        #1 rst_n = 1;
        for (int cyc = 0; cyc < 9; cyc++) begin
            req = 4'b0001;
            drive(0, 32'b01110001, 8);
            tick();
            checks++;
            if ({gnt, busy, match, match_cnt} !== {m_gnt(), m_busy, m_match, m_cnt})
                $display("FAIL postrst cyc%0d: got gnt=%b busy=%b match=%b cnt=%0d, want gnt=%b busy=%b match=%b cnt=%0d",
                         cyc, gnt, busy, match, match_cnt, m_gnt(), m_busy, m_match, m_cnt);
            else passes++;
        end
        checks++;
        if ({match, match_cnt} !== {1'b1, 16'd1})
            $display("FAIL postrst_pattern: got match=%b cnt=%0d want 1/1", match, match_cnt);
        else passes++;
    endtask

    task automatic test_random();
        int mode = 0;
        logic [PAT_W-1:0] pats [4] = '{8'hFF, 8'h00, 8'b01110001, 8'hAA};
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 32 == 0) mode = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) req = NCH'($urandom);
            din = (mode == 0) ? NCH'($urandom) : (mode == 1) ? '1 : '0;
            cfg_we = ($urandom_range(0, 49) == 0);
            cfg_pattern = ($urandom_range(0, 3) == 3) ? PAT_W'($urandom) : pats[$urandom_range(0, 3)];
            tick();
            checks++;
            if ({gnt, busy, match, match_cnt} !== {m_gnt(), m_busy, m_match, m_cnt})
                $display("FAIL rand cyc%0d: got gnt=%b busy=%b match=%b cnt=%0d, want gnt=%b busy=%b match=%b cnt=%0d",
                         cyc, gnt, busy, match, match_cnt, m_gnt(), m_busy, m_match, m_cnt);
            else passes++;
            if (m_match) begin
                checks++;
                if (match_ch !== 2'(m_mch)) $display("FAIL rand_ch cyc%0d: got %0d want %0d", cyc, match_ch, m_mch); else passes++;
            end
        end
        cfg_we = 0;
    endtask

    initial begin
        m_reset();
        test_reset();
        test_single();
        test_overlap();
        test_round_robin();
        test_isolation();
        test_config();
        test_run_cfg_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
